// File: rtl/stream_arbiter_rr_pkg.sv
// Shared helpers for the round-robin stream arbiter family.
package stream_arbiter_pkg;

  // Width of an index into n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_if.sv
// Bundle of the requester streams and the shared output stream.
interface stream_arbiter_rr_if
  import stream_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_WIDTH = clog2_min1(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]            valid_input;
  logic [NUM_INPUTS-1:0]            ready_input;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_input;
  logic [NUM_INPUTS-1:0]            last_input;
  logic                             valid_output;
  logic                             ready_output;
  logic [DATA_WIDTH-1:0]            data_output;
  logic                             last_output;
  logic [ID_WIDTH-1:0]              id_output;

  // The arbiter itself takes the slave view.
  modport slave (
    input  valid_input, data_input, last_input, ready_output,
    output ready_input, valid_output, data_output, last_output, id_output
  );

  modport master (
    output valid_input, data_input, last_input, ready_output,
    input  ready_input, valid_output, data_output, last_output, id_output
  );

endinterface

// File: rtl/stream_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping to 0.
module stream_rr_select
  import stream_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int ID_WIDTH = clog2_min1(N)
) (
  input  logic [N-1:0]        eligible,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                grant_valid,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic                hi_found;
  logic                lo_found;
  logic [ID_WIDTH-1:0] hi_idx;
  logic [ID_WIDTH-1:0] lo_idx;

  // Indices at or above ptr win over the wrapped-around ones below it.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) begin
        if (ID_WIDTH'(i) >= ptr) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = ID_WIDTH'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = ID_WIDTH'(i);
        end
      end
    end
    grant_valid = hi_found || lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/stream_arbiter_rr.sv
// Packet-granular round-robin arbiter feeding one registered valid/ready output slot.
module stream_arbiter_rr
  import stream_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_in,
  output logic                locked,
  stream_arbiter_rr_if.slave  bus
);

  localparam int ID_WIDTH = clog2_min1(NUM_INPUTS);
  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_INPUTS - 1);

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   locked_id_q, locked_id_d;
  logic                  locked_q, locked_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] ready_vec;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  load_ok;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  // A held packet narrows eligibility to its owner, whether or not it is currently valid.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eligible[i] = locked_q ? (locked_id_q == ID_WIDTH'(i)) : bus.valid_input[i];
    end
  end

  stream_rr_select #(
    .N (NUM_INPUTS)
  ) u_select (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    load_ok   = !valid_q || bus.ready_output;
    ready_vec = '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_valid && (grant_idx == ID_WIDTH'(i))) begin
        ready_vec[i] = rst && load_ok && enable_in;
        sel_data     = bus.data_input[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last     = bus.last_input[i];
      end
    end
    xfer = |(ready_vec & bus.valid_input);
  end

  // Next-state for the output slot, the packet lock and the round-robin pointer.
  always_comb begin
    ptr_d       = ptr_q;
    locked_id_d = locked_id_q;
    locked_d    = locked_q;
    valid_d     = valid_q;
    data_d      = data_q;
    last_d      = last_q;
    id_d        = id_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      last_d  = sel_last;
      id_d    = grant_idx;
      if (sel_last) begin
        locked_d = 1'b0;
        ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_WIDTH'(1);
      end else begin
        locked_d    = 1'b1;
        locked_id_d = grant_idx;
      end
    end else if (load_ok) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      locked_id_q <= '0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      id_q        <= '0;
    end else begin
      ptr_q       <= ptr_d;
      locked_id_q <= locked_id_d;
      locked_q    <= locked_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      id_q        <= id_d;
    end
  end

  assign bus.ready_input  = ready_vec;
  assign bus.valid_output = valid_q;
  assign bus.data_output  = data_q;
  assign bus.last_output  = last_q;
  assign bus.id_output    = id_q;
  assign locked           = locked_q;

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Bench for stream_arbiter_rr: a two-input instance scored against a reference model,
// plus a three-input instance for wrap order and asynchronous reset.
module tb_stream_arbiter_rr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enA = 1'b1;
  logic enB = 1'b1;
  logic lockedA;
  logic lockedB;

  stream_arbiter_rr_if #(.NUM_INPUTS(2), .DATA_WIDTH(32)) ifA ();
  stream_arbiter_rr_if #(.NUM_INPUTS(3), .DATA_WIDTH(8))  ifB ();

  stream_arbiter_rr #(.NUM_INPUTS(2), .DATA_WIDTH(32)) dutA (
    .clk       (clk),
    .rst       (rst),
    .enable_in (enA),
    .locked    (lockedA),
    .bus       (ifA.slave)
  );

  stream_arbiter_rr #(.NUM_INPUTS(3), .DATA_WIDTH(8)) dutB (
    .clk       (clk),
    .rst       (rst),
    .enable_in (enB),
    .locked    (lockedB),
    .bus       (ifB.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] id;
  } beatT;

  beatT sbq[$];
  int   expIds[$];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] l,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic en, input logic rdy);
    ifA.valid_input  = v;
    ifA.last_input   = l;
    ifA.data_input   = {d1, d0};
    enA              = en;
    ifA.ready_output = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model of the two-input arbiter, evaluated mid-cycle when inputs are stable.
  initial begin
    int   mPtr;
    int   mLockId;
    bit   mLocked;
    bit   mSlot;
    bit   loadOk;
    bit   found;
    int   g;
    int   idx;
    logic [1:0] elig;
    logic [1:0] expReady;
    beatT e;
    mPtr = 0; mLockId = 0; mLocked = 0; mSlot = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mPtr = 0; mLockId = 0; mLocked = 0; mSlot = 0;
        sbq.delete();
        checkOutput("rst_ready", 64'(ifA.ready_input), 64'h0);
        checkOutput("rst_vout", 64'(ifA.valid_output), 64'h0);
        checkOutput("rst_locked", 64'(lockedA), 64'h0);
      end else begin
        loadOk = !mSlot || ifA.ready_output;
        elig   = mLocked ? 2'(1 << mLockId) : ifA.valid_input;
        found  = 0;
        g      = 0;
        for (int k = 0; k < 2; k++) begin
          idx = (mPtr + k) % 2;
          if (!found && elig[idx]) begin
            found = 1;
            g     = idx;
          end
        end
        expReady = (found && loadOk && enA) ? 2'(1 << g) : 2'b00;
        checkOutput("ready", 64'(ifA.ready_input), 64'(expReady));
        checkOutput("vout", 64'(ifA.valid_output), 64'(mSlot));
        checkOutput("locked", 64'(lockedA), 64'(mLocked));
        if (mSlot && ifA.ready_output) begin
          if (sbq.size() == 0) begin
            checkOutput("sb_size", 64'(sbq.size()), 64'h1);
          end else begin
            e = sbq.pop_front();
            checkOutput("out_data", 64'(ifA.data_output), 64'(e.data));
            checkOutput("out_last", 64'(ifA.last_output), 64'(e.last));
            checkOutput("out_id", 64'(ifA.id_output), 64'(e.id));
          end
        end
        if (|(ifA.valid_input & expReady)) begin
          e.data = ifA.data_input[g*32 +: 32];
          e.last = ifA.last_input[g];
          e.id   = 32'(g);
          sbq.push_back(e);
          mSlot = 1;
          if (e.last) begin
            mLocked = 0;
            mPtr    = (g == 1) ? 0 : g + 1;
          end else begin
            mLocked = 1;
            mLockId = g;
          end
        end else if (loadOk) begin
          mSlot = 0;
        end
      end
    end
  end

  initial begin
    int eid;
    ifA.valid_input  = 2'b11;
    ifA.last_input   = 2'b11;
    ifA.data_input   = {32'h200, 32'h100};
    ifA.ready_output = 1'b1;
    ifB.valid_input  = 3'b000;
    ifB.last_input   = 3'b000;
    ifB.data_input   = 24'h0;
    ifB.ready_output = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_data", 64'(ifA.data_output), 64'h0);
    checkOutput("rst_last", 64'(ifA.last_output), 64'h0);
    checkOutput("rst_id", 64'(ifA.id_output), 64'h0);
    checkOutput("rst_readyB", 64'(ifB.ready_input), 64'h0);
    rst = 1'b1;
    #1;
    checkOutput("first_grant", 64'(ifA.ready_input), 64'h1);

    // Single-beat packets from both requesters alternate.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2'b11, 2'b11, 32'h100 + 32'(k), 32'h200 + 32'(k), 1'b1, 1'b1);
      if (k == 0) checkOutput("first_id", 64'(ifA.id_output), 64'h0);
    end

    // Three-beat packet from input 1 holds the grant.
    applyStimulus(2'b10, 2'b00, 32'h111, 32'h301, 1'b1, 1'b1);
    checkOutput("lock_set", 64'(lockedA), 64'h1);
    applyStimulus(2'b11, 2'b01, 32'h112, 32'h302, 1'b1, 1'b1);
    checkOutput("lock_id", 64'(ifA.id_output), 64'h1);
    applyStimulus(2'b11, 2'b11, 32'h113, 32'h303, 1'b1, 1'b1);
    checkOutput("lock_clr", 64'(lockedA), 64'h0);
    applyStimulus(2'b01, 2'b01, 32'h114, 32'h0, 1'b1, 1'b1);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);

    // Downstream stall with 0xA5 held in the slot.
    applyStimulus(2'b01, 2'b01, 32'hA5, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 2'b01, 32'h5A, 32'h0, 1'b1, 1'b0);
      checkOutput("stall_data", 64'(ifA.data_output), 64'hA5);
      checkOutput("stall_ready", 64'(ifA.ready_input), 64'h0);
    end
    applyStimulus(2'b01, 2'b01, 32'h5A, 32'h0, 1'b1, 1'b1);
    checkOutput("reload_data", 64'(ifA.data_output), 64'h5A);
    checkOutput("reload_valid", 64'(ifA.valid_output), 64'h1);

    // Enable gating in the middle of a locked packet.
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h401, 1'b1, 1'b1);
    checkOutput("en_lock", 64'(lockedA), 64'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 2'b00, 32'h9, 32'h402, 1'b0, 1'b1);
      checkOutput("en_ready", 64'(ifA.ready_input), 64'h0);
    end
    checkOutput("en_drain", 64'(ifA.valid_output), 64'h0);
    checkOutput("en_hold", 64'(lockedA), 64'h1);
    applyStimulus(2'b11, 2'b00, 32'h9, 32'h402, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b01, 2'b00, 32'h9, 32'h403, 1'b1, 1'b1);
      checkOutput("wait_ready0", 64'(ifA.ready_input[0]), 64'h0);
    end
    applyStimulus(2'b11, 2'b10, 32'h9, 32'h403, 1'b1, 1'b1);
    applyStimulus(2'b01, 2'b01, 32'h10, 32'h0, 1'b1, 1'b1);

    // Random traffic, stalls and gating.
    for (int k = 0; k < 80; k++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    end
    checkOutput("sb_left", 64'(sbq.size()), 64'h0);

    // Three requesters: grant order wraps 0,1,2,0.
    ifB.valid_input = 3'b111;
    ifB.last_input  = 3'b111;
    ifB.data_input  = {8'h32, 8'h31, 8'h30};
    for (int k = 0; k < 4; k++) begin
      expIds.push_back(k % 3);
      @(posedge clk);
      #1;
      eid = expIds.pop_front();
      checkOutput("wrap_id", 64'(ifB.id_output), 64'(eid));
      checkOutput("wrap_data", 64'(ifB.data_output), 64'(8'h30 + 8'(eid)));
      checkOutput("wrap_valid", 64'(ifB.valid_output), 64'h1);
    end

    // Asynchronous reset in the middle of a packet.
    ifB.valid_input = 3'b010;
    ifB.last_input  = 3'b000;
    ifB.data_input  = {8'h0, 8'h41, 8'h0};
    @(posedge clk);
    #1;
    checkOutput("mid_lock", 64'(lockedB), 64'h1);
    checkOutput("mid_id", 64'(ifB.id_output), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_lock", 64'(lockedB), 64'h0);
    checkOutput("async_valid", 64'(ifB.valid_output), 64'h0);
    checkOutput("async_ready", 64'(ifB.ready_input), 64'h0);
    ifB.valid_input = 3'b111;
    ifB.last_input  = 3'b111;
    ifB.data_input  = {8'h32, 8'h31, 8'h30};
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_id", 64'(ifB.id_output), 64'h0);
    checkOutput("post_rst_valid", 64'(ifB.valid_output), 64'h1);
    checkOutput("post_rst_data", 64'(ifB.data_output), 64'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
